// File: rtl/i8255_pkg.sv
// Shared constants and types for the i8255-style parallel port block.
package i8255_pkg;

    typedef enum logic [1:0] {
        SEL_PA   = 2'd0,
        SEL_PB   = 2'd1,
        SEL_PC   = 2'd2,
        SEL_CTRL = 2'd3
    } sel_e;

    localparam int CTRL_MODE    = 7;
    localparam int CTRL_PA_DIR  = 4;
    localparam int CTRL_PCH_DIR = 3;
    localparam int CTRL_PB_DIR  = 1;
    localparam int CTRL_PCL_DIR = 0;

    localparam logic [7:0] CTRL_RESET = 8'h9B;

    // One latch's write request for a single clock edge.
    typedef struct packed {
        logic       ld;
        logic       clr;
        logic       bit_we;
        logic [2:0] bit_sel;
        logic       bit_val;
        logic [7:0] data;
    } latch_wr_t;

endpackage

// File: rtl/i8255_port.sv
// One 8-bit port: output latch, per-nibble direction, tristate pins and read mux.
module i8255_port
    import i8255_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  latch_wr_t wr,
    input  logic [1:0] dir,
    output logic [7:0] rdata,
    inout  wire  [7:0] pins
);

    logic [7:0] latch;
    logic [7:0] in_mask;

    assign in_mask = {{4{dir[1]}}, {4{dir[0]}}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            latch <= 8'h00;
        else if (wr.clr)
            latch <= 8'h00;
        else if (wr.ld)
            latch <= wr.data;
        else if (wr.bit_we)
            latch[wr.bit_sel] <= wr.bit_val;
    end

    for (genvar i = 0; i < 8; i++) begin : g_pin
        assign pins[i] = in_mask[i] ? 1'bz : latch[i];
    end

    // Output bits read back the latch, input bits read the pin.
    assign rdata = (latch & ~in_mask) | (pins & in_mask);

endmodule

// File: rtl/i8255_top.sv
// i8255-style PPI, mode 0 only. Define I8255_BSR_EN to enable port C bit set/reset.
module i8255_top
    import i8255_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [1:0] a,
    input  logic [7:0] d,
    output logic [7:0] dout,
    output logic       dout_oe,
    inout  wire  [7:0] pa,
    inout  wire  [7:0] pb,
    inout  wire  [7:0] pc
);

    logic       wr_en;
    logic       mode_set;
    logic       bsr;
    logic [7:0] ctrl;
    logic [7:0] pa_rd, pb_rd, pc_rd;
    latch_wr_t  pa_wr, pb_wr, pc_wr;

    assign wr_en    = !cs_n && !wr_n;
    assign mode_set = wr_en && (a == SEL_CTRL) && d[CTRL_MODE];

`ifdef I8255_BSR_EN
    assign bsr = wr_en && (a == SEL_CTRL) && !d[CTRL_MODE];
`else
    assign bsr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ctrl <= CTRL_RESET;
        else if (mode_set)
            ctrl <= d;
    end

    assign pa_wr = '{ld: wr_en && (a == SEL_PA), clr: mode_set, bit_we: 1'b0,
                     bit_sel: 3'd0, bit_val: 1'b0, data: d};
    assign pb_wr = '{ld: wr_en && (a == SEL_PB), clr: mode_set, bit_we: 1'b0,
                     bit_sel: 3'd0, bit_val: 1'b0, data: d};
    assign pc_wr = '{ld: wr_en && (a == SEL_PC), clr: mode_set, bit_we: bsr,
                     bit_sel: d[3:1], bit_val: d[0], data: d};

    i8255_port u_pa (
        .clk(clk), .reset_n(reset_n), .wr(pa_wr),
        .dir({ctrl[CTRL_PA_DIR], ctrl[CTRL_PA_DIR]}), .rdata(pa_rd), .pins(pa)
    );

    i8255_port u_pb (
        .clk(clk), .reset_n(reset_n), .wr(pb_wr),
        .dir({ctrl[CTRL_PB_DIR], ctrl[CTRL_PB_DIR]}), .rdata(pb_rd), .pins(pb)
    );

    i8255_port u_pc (
        .clk(clk), .reset_n(reset_n), .wr(pc_wr),
        .dir({ctrl[CTRL_PCH_DIR], ctrl[CTRL_PCL_DIR]}), .rdata(pc_rd), .pins(pc)
    );

    // A simultaneous write strobe suppresses the read.
    assign dout_oe = !cs_n && !rd_n && wr_n;

    always_comb begin
        dout = 8'h00;
        if (dout_oe) begin
            case (a)
                SEL_PA:  dout = pa_rd;
                SEL_PB:  dout = pb_rd;
                SEL_PC:  dout = pc_rd;
                default: dout = ctrl;
            endcase
        end
    end

endmodule

// File: tb/tb_i8255_top.sv
// Directed bench for i8255_top: pulled pins reveal high-Z (pa pulls low, pb/pc pull high).
module tb_i8255_top;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [1:0] a = 2'd0;
    logic [7:0] d = 8'h00;
    wire  [7:0] dout;
    wire        dout_oe;
    tri0  [7:0] pa;
    tri1  [7:0] pb;
    tri1  [7:0] pc;

    logic       pb_en = 1'b0;
    logic [7:0] pb_ext = 8'h00;
    assign pb = pb_en ? pb_ext : 8'hzz;

`ifdef I8255_BSR_EN
    localparam bit BSR = 1'b1;
`else
    localparam bit BSR = 1'b0;
`endif

    i8255_top dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a(a), .d(d), .dout(dout), .dout_oe(dout_oe), .pa(pa), .pb(pb), .pc(pc)
    );

    always #5 clk = ~clk;

    // Model: control byte and three latches, behaviour described in port terms.
    logic [7:0] m_ctrl = 8'h9B;
    logic [7:0] m_lat [3] = '{default: 8'h00};
    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] inputs_of(int p);
        case (p)
            0:       return m_ctrl[4] ? 8'hFF : 8'h00;
            1:       return m_ctrl[1] ? 8'hFF : 8'h00;
            default: return {(m_ctrl[3] ? 4'hF : 4'h0), (m_ctrl[0] ? 4'hF : 4'h0)};
        endcase
    endfunction

    function automatic logic [7:0] pin_exp(int p);
        logic [7:0] ext;
        if (p == 1 && pb_en) ext = pb_ext;
        else                 ext = (p == 0) ? 8'h00 : 8'hFF;
        return (m_lat[p] & ~inputs_of(p)) | (ext & inputs_of(p));
    endfunction

    function automatic logic [7:0] dout_exp();
        if (cs_n || rd_n || !wr_n) return 8'h00;
        if (a == 2'd3) return m_ctrl;
        return pin_exp(int'(a));
    endfunction

    function automatic logic oe_exp();
        return !cs_n && !rd_n && wr_n;
    endfunction

    task automatic model_reset();
        m_ctrl = 8'h9B;
        for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
    endtask

    task automatic model_write(input logic [1:0] aa, input logic [7:0] dd);
        if (aa != 2'd3) begin
            m_lat[aa] = dd;
        end else if (dd[7]) begin
            m_ctrl = dd;
            for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
        end else if (BSR) begin
            m_lat[2][dd[3:1]] = dd[0];
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check8("pa_cyc", pa, pin_exp(0));
        check8("pb_cyc", pb, pin_exp(1));
        check8("pc_cyc", pc, pin_exp(2));
        check8("dout_cyc", dout, dout_exp());
        check8("oe_cyc", {7'd0, dout_oe}, {7'd0, oe_exp()});
    end

    task automatic wr(input logic [1:0] aa, input logic [7:0] dd);
        cs_n = 1'b0; wr_n = 1'b0; a = aa; d = dd;
        @(posedge clk);
        model_write(aa, dd);
        #1 cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] aa, output logic [7:0] val);
        cs_n = 1'b0; rd_n = 1'b0; a = aa;
        @(negedge clk);
        #1 val = dout;
        @(posedge clk);
        #1 cs_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] v;

    initial begin
        // Reset holds all pins released.
        model_reset();
        #12;
        check8("rst_pa_z", pa, 8'h00);
        check8("rst_pb_z", pb, 8'hFF);
        check8("rst_pc_z", pc, 8'hFF);
        check8("rst_oe", {7'd0, dout_oe}, 8'h00);
        @(posedge clk); #1 reset_n = 1'b1;
        idle(1);
        rd(2'd3, v); check8("rst_ctrl", v, 8'h9B);

        // All outputs.
        wr(2'd3, 8'h80); wr(2'd0, 8'hFF); idle(1);
        check8("allout_pa", pa, 8'hFF);
        check8("allout_pb", pb, 8'h00);
        check8("allout_pc", pc, 8'h00);

        // Mixed directions.
        wr(2'd3, 8'h83); idle(1);
        check8("mix_pa", pa, 8'h00);
        check8("mix_pb_z", pb, 8'hFF);
        check8("mix_pc", pc, 8'h0F);
        rd(2'd2, v); check8("mix_rd_pc", v, 8'h0F);
        pb_en = 1'b1; pb_ext = 8'h5A;
        rd(2'd1, v); check8("mix_rd_pb", v, 8'h5A);
        pb_en = 1'b0;
        wr(2'd0, 8'hFF); idle(1);
        check8("mix_pa_ff", pa, 8'hFF);

        // Other directions: PC high and PB inputs.
        wr(2'd3, 8'h8A); wr(2'd2, 8'h5A); idle(1);
        rd(2'd2, v); check8("pc_nib_rd", v, 8'hFA);

        // Bit set/reset on PC.
        wr(2'd3, 8'h80);
        wr(2'd3, 8'h0F); idle(1);
        check8("bsr_set7", pc, BSR ? 8'h80 : 8'h00);
        rd(2'd3, v); check8("bsr_ctrl", v, 8'h80);
        wr(2'd3, 8'h05); idle(1);
        check8("bsr_set2", pc, BSR ? 8'h84 : 8'h00);
        wr(2'd3, 8'h0E); idle(1);
        check8("bsr_clr7", pc, BSR ? 8'h04 : 8'h00);

        // A strobe held over several edges acts once.
        cs_n = 1'b0; wr_n = 1'b0; a = 2'd1; d = 8'hA5;
        repeat (3) begin @(posedge clk); model_write(2'd1, 8'hA5); end
        #1 cs_n = 1'b1; wr_n = 1'b1;
        idle(1);
        check8("hold_pb", pb, 8'hA5);

        // Reset pulse between edges.
        wr(2'd0, 8'hFF); idle(1);
        check8("pre_rst_pa", pa, 8'hFF);
        #2 reset_n = 1'b0; model_reset();
        #1 check8("async_pa_z", pa, 8'h00);
        check8("async_pb_z", pb, 8'hFF);
        #1 reset_n = 1'b1;
        idle(1);
        rd(2'd3, v); check8("async_ctrl", v, 8'h9B);

        // Reset beats a write strobe spanning an edge.
        cs_n = 1'b0; wr_n = 1'b0; a = 2'd3; d = 8'h80;
        reset_n = 1'b0; model_reset();
        @(posedge clk);
        #1 cs_n = 1'b1; wr_n = 1'b1;
        reset_n = 1'b1;
        idle(1);
        rd(2'd3, v); check8("rst_wins", v, 8'h9B);

        // Simultaneous read and write strobes.
        wr(2'd3, 8'h80);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a = 2'd0; d = 8'h3C;
        #1 check8("simul_oe", {7'd0, dout_oe}, 8'h00);
        check8("simul_dout", dout, 8'h00);
        @(posedge clk); model_write(2'd0, 8'h3C);
        #1 cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        idle(1);
        check8("simul_pa", pa, 8'h3C);

        // Deselected strobes do nothing.
        cs_n = 1'b1; wr_n = 1'b0; a = 2'd0; d = 8'h99;
        idle(2);
        wr_n = 1'b1;
        check8("cs_ignored", pa, 8'h3C);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i8255_top.md
I8255_TOP -- requirements
Module: i8255_top

Interface
REQ-001 The module SHALL have these ports: clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 The module SHALL have these ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 The module SHALL have these ports: cs_n  in  1  chip select, active low.
REQ-004 The module SHALL have these ports: rd_n  in  1  read strobe, active low.
REQ-005 The module SHALL have these ports: wr_n  in  1  write strobe, active low.
REQ-006 The module SHALL have these ports: a  in  2  register select (0=PA, 1=PB, 2=PC, 3=control).
REQ-007 The module SHALL have these ports: d  in  8  write data bus.
REQ-008 The module SHALL have these ports: dout  out  8  read data; dout_oe  out  1  high while a read is active.
REQ-009 The module SHALL have these ports: pa, pb, pc  inout  8 each  peripheral ports; driven when configured as output, else high-Z.
REQ-010 The module SHALL have no parameters.

Function
REQ-011 A write SHALL occur on each rising clk edge with cs_n=0 and wr_n=0; repeated edges within one strobe SHALL be idempotent.
REQ-012 Writes to a=0/1/2 SHALL load the PA/PB/PC output latch, whatever the port direction.
REQ-013 A write to a=3 with d[7]=1 SHALL be a mode set: control<=d; PA, PB and PC latches cleared to 0x00 in the same cycle.
REQ-014 Control bits: d[4]=PA dir, d[3]=PC[7:4] dir, d[1]=PB dir, d[0]=PC[3:0] dir (1=input, 0=output); d[6:5] and d[2] stored, and all ports operate in mode 0 regardless.
REQ-015 A write to a=3 with d[7]=0 SHALL be bit set/reset: PC latch bit d[3:1] <= d[0]; other PC bits and the control register unchanged.
REQ-016 Output-configured port bits SHALL drive their latch value from the edge after the write; input-configured bits SHALL be high-Z.
REQ-017 Reads SHALL be combinational: dout_oe = !cs_n & !rd_n & wr_n.
REQ-018 Read data: a=0..2 returns the latch for output bits and the pin value for input bits, per nibble for PC; a=3 returns the control register.
REQ-019 When dout_oe=0, dout SHALL be 0x00.
REQ-020 With rd_n=0 and wr_n=0 together, the write SHALL take effect and dout_oe SHALL be 0.
REQ-021 With cs_n=1, strobes SHALL be ignored.

Reset
REQ-022 reset_n=0 SHALL immediately set control=0x9B (all ports input) and all latches to 0x00, leaving pa/pb/pc high-Z, independent of clk.
REQ-023 Reset asserted during a write strobe SHALL win; the write is lost, and writes resume on the first clk edge after release that still meets REQ-011.

Configuration
REQ-024 Macro I8255_BSR_EN: when defined, bit set/reset per REQ-015 is implemented.
REQ-025 When I8255_BSR_EN is undefined, writes to a=3 with d[7]=0 SHALL be ignored and change no state.

Structure
REQ-026 Package i8255_pkg SHALL hold the address constants (PA/PB/PC/CTRL), control bit positions, and the reset control value 0x9B.
REQ-027 Sub-module i8255_port SHALL implement one 8-bit latch with per-nibble direction, tristate drive and read mux; it is instantiated three times.

Verification
REQ-028 Reset: hold reset_n=0 -> pa/pb/pc = Z; after release, read a=3 -> dout=0x9B.
REQ-029 All outputs: write 0x80 to a=3, then 0xFF to a=0 -> pa=0xFF, pb=0x00, pc=0x00.
REQ-030 Mixed mode: after REQ-029, write 0x83 to a=3 -> pa=0x00, pb=Z, pc[7:4]=0, pc[3:0]=Z; drive pb=0x5A externally, read a=1 -> dout=0x5A; write 0xFF to a=0 -> pa=0xFF.
REQ-031 BSR (I8255_BSR_EN defined): after 0x80, write 0x0F to a=3 -> pc=0x80; write 0x0E -> pc=0x00. With the macro undefined, pc stays 0x00.
REQ-032 Reset mid-operation: with pa=0xFF, pulse reset_n low between clk edges -> pa=Z immediately; read a=3 -> 0x9B.
REQ-033 Simultaneous strobes: cs_n=0, rd_n=0, wr_n=0, a=0, d=0x3C with PA output -> dout_oe=0 and pa=0x3C after the edge.
